// File: rtl/counter_scheduler_pkg.sv
// Shared definitions for the counter scheduler: FSM state encoding and default counter width.
// Pure declarations; no latency or backpressure of its own.
package counter_scheduler_pkg;

   localparam int CW_DEFAULT = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/up_counter_en.sv
// CW-bit up-counter with synchronous clear and enable; the result is visible one cycle after clr/en.
// No backpressure: clear wins over enable, and the counter holds when both are low.
module up_counter_en
   import counter_scheduler_pkg::*;
#(
   parameter int CW = CW_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   output logic [CW-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         q <= '0;
      end else if (en) begin
         q <= q + CW'(1);
      end
   end

endmodule

// File: rtl/counter_scheduler.sv
// Round-robin scheduler for a shared up-counter: grants one requester, counts len cycles, then pulses done.
// gnt rises one cycle after req is seen and done follows len+1 cycles later; other requesters wait while busy.
module counter_scheduler
   import counter_scheduler_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int CW   = CW_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*CW-1:0] len,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   done,
   output logic              busy,
   output logic              cnt_en,
   output logic [CW-1:0]     cnt_q
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_t          state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [IW-1:0]   win_q, win_d;
   logic [CW-1:0]   len_q, len_d;
   logic [NREQ-1:0] gnt_q, gnt_d;

   logic            any_req;
   logic [IW-1:0]   pick;
   logic [IW-1:0]   idx;
   logic [IW-1:0]   ptr_nxt;
   logic            win_req;
   logic            cnt_clr;
   logic            cnt_inc;

   // Lowest rotational offset from the pointer wins, so scan from the far end down.
   always_comb begin
      any_req = 1'b0;
      pick    = ptr_q;
      idx     = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = IW'((int'(ptr_q) + k) % NREQ);
         if (req[idx]) begin
            any_req = 1'b1;
            pick    = idx;
         end
      end
   end

   assign ptr_nxt = (int'(win_q) == NREQ - 1) ? '0 : win_q + IW'(1);
   assign win_req = req[win_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         win_q   <= '0;
         len_q   <= '0;
         gnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         len_q   <= len_d;
         gnt_q   <= gnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      len_d   = len_q;
      gnt_d   = gnt_q;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               win_d       = pick;
               len_d       = len[int'(pick)*CW +: CW];
               gnt_d       = '0;
               gnt_d[pick] = 1'b1;
               state_d     = CLEAR;
            end
         end
         CLEAR: begin
            cnt_clr = 1'b1;
            if (!win_req) begin
               state_d = IDLE;
               gnt_d   = '0;
               ptr_d   = ptr_nxt;
            end else if (len_q == '0) begin
               state_d = DONE;
            end else begin
               state_d = RUN;
            end
         end
         RUN: begin
            // A dropped request beats terminal count and freezes the counter.
            if (!win_req) begin
               state_d = IDLE;
               gnt_d   = '0;
               ptr_d   = ptr_nxt;
            end else begin
               cnt_inc = 1'b1;
               if (cnt_q == len_q - CW'(1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            gnt_d   = '0;
            ptr_d   = ptr_nxt;
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   up_counter_en #(
      .CW(CW)
   ) u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (cnt_clr),
      .en  (cnt_inc),
      .q   (cnt_q)
   );

   assign gnt    = gnt_q;
   assign done   = (state_q == DONE) ? gnt_q : '0;
   assign busy   = (state_q != IDLE);
   assign cnt_en = cnt_inc;

endmodule

// File: tb/tb_counter_scheduler.sv
// Bench for counter_scheduler: timeline model of each grant plus directed scenarios with literal expectations.
module tb_counter_scheduler;

   localparam int NREQ = 2;
   localparam int CW   = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NREQ-1:0]   req = '0;
   logic [NREQ*CW-1:0] len = '0;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   done;
   logic              busy;
   logic              cnt_en;
   logic [CW-1:0]     cnt_q;

   int n_chk  = 0;
   int n_pass = 0;

   counter_scheduler #(
      .NREQ(NREQ),
      .CW  (CW)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .len    (len),
      .gnt    (gnt),
      .done   (done),
      .busy   (busy),
      .cnt_en (cnt_en),
      .cnt_q  (cnt_q)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   // Model: a grant is a timeline. Age 1 is the first gnt cycle, ages 2..L+1 count,
   // age L+2 pulses done; a dropped request ends the grant early.
   bit m_act = 1'b0;
   int m_w   = 0;
   int m_len = 0;
   int m_age = 0;
   int m_cnt = 0;
   int m_ptr = 0;

   always @(negedge clk) begin
      logic [NREQ-1:0] e_gnt;
      logic [NREQ-1:0] e_done;
      logic            e_en;
      int              cand;
      e_gnt  = m_act ? NREQ'(1 << m_w) : '0;
      e_done = (m_act && m_age == m_len + 2) ? e_gnt : '0;
      e_en   = m_act && m_age >= 2 && m_age <= m_len + 1 && req[m_w];
      chk("mdl_gnt",    32'(gnt),    32'(e_gnt));
      chk("mdl_done",   32'(done),   32'(e_done));
      chk("mdl_busy",   32'(busy),   32'(m_act));
      chk("mdl_cnt_en", 32'(cnt_en), 32'(e_en));
      chk("mdl_cnt_q",  32'(cnt_q),  32'(m_cnt));
      chk("inv_onehot", 32'($onehot0(gnt)), 32'(1));
      chk("inv_done_in_gnt", 32'((done & ~gnt) == '0), 32'(1));

      if (rst) begin
         m_act = 1'b0;
         m_ptr = 0;
         m_cnt = 0;
      end else if (m_act) begin
         if (m_age == m_len + 2) begin
            m_act = 1'b0;
            m_ptr = (m_w + 1) % NREQ;
         end else begin
            if (m_age == 1) m_cnt = 0;
            else if (req[m_w]) m_cnt = (m_cnt + 1) % (1 << CW);
            if (!req[m_w]) begin
               m_act = 1'b0;
               m_ptr = (m_w + 1) % NREQ;
            end else begin
               m_age++;
            end
         end
      end else begin
         for (int k = 0; k < NREQ; k++) begin
            cand = (m_ptr + k) % NREQ;
            if (!m_act && req[cand]) begin
               m_act = 1'b1;
               m_w   = cand;
               m_len = int'(len[cand*CW +: CW]);
               m_age = 1;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
      $fatal(1);
   end

   initial begin
      int n_en;
      int n_done;
      int dn_cyc[4];
      int dn_val[4];
      int exp_cyc[4];
      int exp_val[4];
      exp_cyc = '{4, 12, 17, 25};
      exp_val = '{1, 2, 1, 2};

      // Reset state
      tick();
      tick();
      @(negedge clk);
      chk("rst_gnt",    32'(gnt),    32'(0));
      chk("rst_done",   32'(done),   32'(0));
      chk("rst_busy",   32'(busy),   32'(0));
      chk("rst_cnt_en", 32'(cnt_en), 32'(0));
      chk("rst_cnt_q",  32'(cnt_q),  32'(0));
      tick();
      rst = 1'b0;
      tick();

      // Single request, len0=3
      n_en = 0;
      for (int c = 0; c <= 7; c++) begin
         if (c == 0) begin len = {3'd0, 3'd3}; req = 2'b01; end
         if (c == 6) req = 2'b00;
         @(negedge clk);
         if (cnt_en) n_en++;
         if (c == 1) chk("t1_gnt_c1", 32'(gnt), 32'(2'b01));
         if (c >= 2 && c <= 4) chk("t1_cnt_en", 32'(cnt_en), 32'(1));
         if (c == 5) begin
            chk("t1_cnt_q_c5", 32'(cnt_q), 32'(3));
            chk("t1_done_c5",  32'(done),  32'(2'b01));
         end
         if (c == 6) chk("t1_gnt_c6", 32'(gnt), 32'(0));
         tick();
      end
      chk("t1_en_cycles", 32'(n_en), 32'(3));

      // Contention after reset: len0=2, len1=5, req=11 held
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_done = 0;
      for (int c = 0; c <= 25; c++) begin
         if (c == 0) begin len = {3'd5, 3'd2}; req = 2'b11; end
         @(negedge clk);
         if (done != '0 && n_done < 4) begin
            dn_cyc[n_done] = c;
            dn_val[n_done] = int'(done);
            n_done++;
         end
         if (c == 1)  chk("t2_gnt_c1",  32'(gnt), 32'(2'b01));
         if (c == 6)  chk("t2_gnt_c6",  32'(gnt), 32'(2'b10));
         if (c == 14) chk("t2_gnt_c14", 32'(gnt), 32'(2'b01));
         if (c == 19) chk("t2_gnt_c19", 32'(gnt), 32'(2'b10));
         tick();
      end
      req = 2'b00;
      chk("t2_done_count", 32'(n_done), 32'(4));
      for (int i = 0; i < 4; i++) begin
         if (i < n_done) begin
            chk("t2_done_cycle", 32'(dn_cyc[i]), 32'(exp_cyc[i]));
            chk("t2_done_value", 32'(dn_val[i]), 32'(exp_val[i]));
         end
      end
      tick();
      tick();

      // len=0 on requester 1
      for (int c = 0; c <= 4; c++) begin
         if (c == 0) begin len = {3'd0, 3'd0}; req = 2'b10; end
         if (c == 3) req = 2'b00;
         @(negedge clk);
         chk("t3_no_cnt_en", 32'(cnt_en), 32'(0));
         if (c == 1) chk("t3_gnt_c1", 32'(gnt), 32'(2'b10));
         if (c == 2) begin
            chk("t3_done_c2",  32'(done),  32'(2'b10));
            chk("t3_cnt_q_c2", 32'(cnt_q), 32'(0));
         end
         tick();
      end

      // Abort: req0 dropped at cnt_q=2, len0=6, req1 (len1=1) pending
      for (int c = 0; c <= 9; c++) begin
         if (c == 0) begin len = {3'd1, 3'd6}; req = 2'b11; end
         if (c == 4) req = 2'b10;
         if (c == 9) req = 2'b00;
         @(negedge clk);
         if (c <= 7) chk("t4_no_done", 32'(done), 32'(0));
         if (c == 1) chk("t4_gnt_c1", 32'(gnt), 32'(2'b01));
         if (c == 4) begin
            chk("t4_cnt_q_c4",  32'(cnt_q),  32'(2));
            chk("t4_cnt_en_c4", 32'(cnt_en), 32'(0));
         end
         if (c == 5) begin
            chk("t4_gnt_c5",   32'(gnt),   32'(0));
            chk("t4_busy_c5",  32'(busy),  32'(0));
            chk("t4_cnt_q_c5", 32'(cnt_q), 32'(2));
         end
         if (c == 6) chk("t4_gnt_c6", 32'(gnt), 32'(2'b10));
         if (c == 8) begin
            chk("t4_done_c8",  32'(done),  32'(2'b10));
            chk("t4_cnt_q_c8", 32'(cnt_q), 32'(1));
         end
         tick();
      end

      // Reset mid-RUN at cnt_q=4 while the pointer favours requester 1
      for (int c = 0; c <= 16; c++) begin
         if (c == 0)  begin len = {3'd6, 3'd1}; req = 2'b01; end
         if (c == 3)  req = 2'b11;
         if (c == 10) rst = 1'b1;
         if (c == 11) rst = 1'b0;
         if (c == 15) req = 2'b00;
         @(negedge clk);
         if (c == 1) chk("t5_gnt_c1",  32'(gnt),  32'(2'b01));
         if (c == 3) chk("t5_done_c3", 32'(done), 32'(2'b01));
         if (c == 5) chk("t5_gnt_c5",  32'(gnt),  32'(2'b10));
         if (c >= 5 && c <= 11) chk("t5_no_done", 32'(done), 32'(0));
         if (c == 10) chk("t5_cnt_q_c10", 32'(cnt_q), 32'(4));
         if (c == 11) begin
            chk("t5_gnt_c11",   32'(gnt),   32'(0));
            chk("t5_busy_c11",  32'(busy),  32'(0));
            chk("t5_cnt_q_c11", 32'(cnt_q), 32'(0));
         end
         if (c == 12) chk("t5_gnt_c12",  32'(gnt),  32'(2'b01));
         if (c == 14) chk("t5_done_c14", 32'(done), 32'(2'b01));
         tick();
      end

      // Maximum length, len0=7
      n_en = 0;
      for (int c = 0; c <= 11; c++) begin
         if (c == 0)  begin len = {3'd0, 3'd7}; req = 2'b01; end
         if (c == 10) req = 2'b00;
         @(negedge clk);
         if (cnt_en) n_en++;
         if (c == 9) begin
            chk("t6_cnt_q_c9", 32'(cnt_q), 32'(7));
            chk("t6_done_c9",  32'(done),  32'(2'b01));
         end
         if (c == 10) begin
            chk("t6_cnt_q_c10", 32'(cnt_q), 32'(7));
            chk("t6_gnt_c10",   32'(gnt),   32'(0));
         end
         tick();
      end
      chk("t6_en_cycles", 32'(n_en), 32'(7));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/counter_scheduler.md
Name: counter_scheduler

Overview:
- Shares one enable-driven up-counter between NREQ requesters. Each requester asks for a timed count of `len` cycles.
- Round-robin arbitration picks the winner. The block then clears the counter, enables it for exactly `len` cycles, and pulses `done` to the winner.
- Sits between requester logic and the shared counter. The counter is instantiated inside this block.

Parameters:
- NREQ, 2, number of requesters (2..4).
- CW, 3, counter and length width in bits.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- req  input  NREQ  per-requester request level; held high until `done` or abandoned.
- len  input  NREQ*CW  per-requester count length; requester i uses bits [i*CW +: CW].
- gnt  output  NREQ  one-hot grant, registered.
- done  output  NREQ  one-cycle completion pulse to the granted requester.
- busy  output  1  high whenever the state is not IDLE.
- cnt_en  output  1  enable currently driven into the counter (observability).
- cnt_q  output  CW  current counter value.

Behaviour:
- Reset: state IDLE, gnt=0, done=0, busy=0, cnt_en=0, cnt_q=0, round-robin pointer set so req[0] has top priority.
- Reset mid-operation: IDLE on the next edge, no done pulse, counter cleared.
- States: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - If any req is high, pick the first requester at or after the pointer, wrapping.
  - Latch len[winner] into len_q; go to CLEAR.
  - Otherwise stay in IDLE.
- CLEAR (1 cycle):
  - gnt[winner]=1, counter cleared to 0 synchronously.
  - Next state RUN if len_q≠0; DONE if len_q=0.
- RUN:
  - gnt held, cnt_en=1, counter increments each cycle.
  - When cnt_q == len_q-1, next state DONE; cnt_q == len_q in DONE.
  - RUN therefore lasts exactly len_q cycles.
- DONE (1 cycle):
  - done[winner]=1, gnt still high, cnt_en=0, counter holds.
  - Next state IDLE; pointer becomes winner+1 mod NREQ.
- Abort:
  - If req[winner] is low in CLEAR or RUN, next state IDLE.
  - No done pulse; pointer still advances; counter holds its value.
  - In RUN the req-low check takes precedence over terminal count.
  - req is ignored in DONE.
- len_q is frozen at grant; later len changes have no effect on the active grant.
- Timing: req seen in IDLE at cycle t gives:
  - gnt rises at t+1;
  - done at t+2+len;
  - gnt falls at t+3+len;
  - earliest next grant at t+4+len.
- A requester holding req high after done is re-arbitrated; the other requesters have priority over it.
- Counter arithmetic: CW bits, modulo 2^CW. Wrap never occurs in normal operation because len ≤ 2^CW-1.
- Invariants:
  - gnt is zero or one-hot.
  - done is a subset of gnt.
  - cnt_en is high only in RUN.

Decomposition:
- Shared package: state encoding constants (IDLE, CLEAR, RUN, DONE) and the default CW.
- One sub-module: up_counter_en.
  - CW-bit up-counter with synchronous clear and enable.
  - Synchronous active-high rst; clear has priority over enable.
- The scheduler holds the FSM, the round-robin pointer, len_q and the grant register.

Test Plan:
- Single request, req[0]=1, len0=3 at cycle 0:
  - gnt=01 at cycle 1;
  - cnt_en high cycles 2-4;
  - cnt_q=3 and done=01 at cycle 5;
  - gnt=00 at cycle 6.
- Contention, req=11 continuously, len0=2, len1=5:
  - grants alternate 01,10,01,...;
  - done pulses are 2 and 5 RUN cycles apart accordingly;
  - gnt is never multi-hot.
- len=0 on requester 1: gnt=10 at t+1, done=10 at t+2, no cnt_en.
- Abort: req[0] dropped mid-RUN at cnt_q=2 with len0=6 → IDLE the next cycle, no done, cnt_q holds 2, pointer advances so a pending req[1] wins next.
- Reset mid-RUN at cnt_q=4:
  - next cycle gnt=00, busy=0, cnt_q=0, done never pulses;
  - after reset req[0] has priority over req[1] with req=11.
- Max length, len0=7 (CW=3): cnt_q reaches 7 in DONE with no wrap to 0; exactly 7 cnt_en cycles.
